// File: rtl/perf_counters_ctrl.sv
// -----------------------------------------------------------------------------
// perf_counters_ctrl
//
// Shares the single addr/we/data port of perf_counters between the CSR file
// and an internal sweep engine. The sweep engine reads counters FIRST_ADDR..
// LAST_ADDR one at a time and streams them out over a valid/ready interface.
// The CSR side has priority. A starvation counter forces one sweep slot after
// STARVE_LIMIT consecutive CSR wins against a pending sweep read.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   debug_mode_i                  core is in debug mode (write protection)
//   csr_req_i/we_i/addr_i/wdata_i CSR request (granted combinationally)
//   csr_gnt_o                     CSR request accepted this cycle
//   csr_rvalid_o/rdata_o/err_o    CSR response, one cycle after the grant
//   sweep_start_i                 start a sweep (ignored while busy)
//   sweep_busy_o                  sweep in progress
//   sweep_valid_o/ready_i         sweep output handshake
//   sweep_addr_o/data_o/last_o    current sweep beat
//   pc_addr_o/we_o/data_o         shared port towards perf_counters
//   pc_data_i                     read data, combinational from pc_addr_o
//
// Build option
//   PERF_CTRL_DBG_WPROT_EN : when defined, CSR writes made in debug mode are
//   granted but suppressed and answered with csr_err_o=1, csr_rdata_o=0.
//   When undefined, debug_mode_i is ignored and csr_err_o is always 0.
// -----------------------------------------------------------------------------
module perf_counters_ctrl #(
    parameter logic [4:0]  FIRST_ADDR   = 5'd3,
    parameter logic [4:0]  LAST_ADDR    = 5'd31,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        debug_mode_i,
    input  logic        csr_req_i,
    input  logic        csr_we_i,
    input  logic [4:0]  csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic        csr_gnt_o,
    output logic        csr_rvalid_o,
    output logic [31:0] csr_rdata_o,
    output logic        csr_err_o,
    input  logic        sweep_start_i,
    output logic        sweep_busy_o,
    output logic        sweep_valid_o,
    input  logic        sweep_ready_i,
    output logic [4:0]  sweep_addr_o,
    output logic [31:0] sweep_data_o,
    output logic        sweep_last_o,
    output logic [4:0]  pc_addr_o,
    output logic        pc_we_o,
    output logic [31:0] pc_data_o,
    input  logic [31:0] pc_data_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [3:0]  starve_q, starve_d;
    logic        csr_rvalid_q, csr_rvalid_d;
    logic [31:0] csr_rdata_q, csr_rdata_d;
    logic        csr_err_q, csr_err_d;
    logic [4:0]  sweep_addr_q, sweep_addr_d;
    logic [31:0] sweep_data_q, sweep_data_d;
    logic        sweep_last_q, sweep_last_d;

    logic        force_sweep;
    logic        csr_gnt;
    logic        sweep_gnt;
    logic        wr_blocked;

`ifdef PERF_CTRL_DBG_WPROT_EN
    assign wr_blocked = debug_mode_i & csr_we_i;
`else
    logic unused_debug_mode;
    assign unused_debug_mode = debug_mode_i;
    assign wr_blocked        = 1'b0;
`endif

    // Arbitration and shared-port mux
    always_comb begin
        // The starvation counter only ever reaches the limit while in READ.
        force_sweep = (state_q == ST_READ) && (starve_q == STARVE_LIM);
        csr_gnt     = csr_req_i && !force_sweep;
        sweep_gnt   = (state_q == ST_READ) && !csr_gnt;

        pc_addr_o = '0;
        pc_we_o   = 1'b0;
        pc_data_o = '0;
        if (csr_gnt) begin
            pc_addr_o = csr_addr_i;
            pc_we_o   = csr_we_i && !wr_blocked;
            pc_data_o = csr_wdata_i;
        end else if (sweep_gnt) begin
            pc_addr_o = ptr_q;
        end
    end

    // CSR response, one cycle after the grant
    always_comb begin
        csr_rvalid_d = csr_gnt;
        csr_rdata_d  = csr_rdata_q;
        csr_err_d    = 1'b0;
        if (csr_gnt) begin
            csr_rdata_d = csr_we_i ? 32'd0 : pc_data_i;
            csr_err_d   = wr_blocked;
        end
    end

    // Sweep FSM, pointer, beat registers and starvation counter
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        sweep_addr_d = sweep_addr_q;
        sweep_data_d = sweep_data_q;
        sweep_last_d = sweep_last_q;
        starve_d     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (sweep_start_i) begin
                    state_d = ST_READ;
                    ptr_d   = FIRST_ADDR;
                end
            end
            ST_READ: begin
                if (sweep_gnt) begin
                    sweep_addr_d = ptr_q;
                    sweep_data_d = pc_data_i;
                    sweep_last_d = (ptr_q == LAST_ADDR);
                    state_d      = ST_HOLD;
                end else begin
                    starve_d = starve_q + 4'd1;
                end
            end
            ST_HOLD: begin
                if (sweep_ready_i) begin
                    if (ptr_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Never past LAST_ADDR, so the 5-bit add cannot wrap.
                        ptr_d   = ptr_q + 5'd1;
                        state_d = ST_READ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            ptr_q        <= FIRST_ADDR;
            starve_q     <= '0;
            csr_rvalid_q <= 1'b0;
            csr_rdata_q  <= '0;
            csr_err_q    <= 1'b0;
            sweep_addr_q <= '0;
            sweep_data_q <= '0;
            sweep_last_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            starve_q     <= starve_d;
            csr_rvalid_q <= csr_rvalid_d;
            csr_rdata_q  <= csr_rdata_d;
            csr_err_q    <= csr_err_d;
            sweep_addr_q <= sweep_addr_d;
            sweep_data_q <= sweep_data_d;
            sweep_last_q <= sweep_last_d;
        end
    end

    assign csr_gnt_o     = csr_gnt;
    assign csr_rvalid_o  = csr_rvalid_q;
    assign csr_rdata_o   = csr_rdata_q;
    assign csr_err_o     = csr_err_q;
    assign sweep_busy_o  = (state_q != ST_IDLE);
    assign sweep_valid_o = (state_q == ST_HOLD);
    assign sweep_addr_o  = sweep_addr_q;
    assign sweep_data_o  = sweep_data_q;
    assign sweep_last_o  = sweep_last_q;

endmodule

// File: tb/tb_perf_counters_ctrl.sv
// -----------------------------------------------------------------------------
// tb_perf_counters_ctrl
//
// Scoreboard bench for perf_counters_ctrl. The driver issues randomized and
// directed CSR traffic and sweep requests. A monitor on the falling edge
// predicts arbitration from the starvation rule, pushes expected CSR responses
// and sweep beats into queues, and pops/compares them when the DUT presents
// them. The counter file behind the shared port is a plain array.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_perf_counters_ctrl;

    localparam logic [4:0] FIRST = 5'd3;
    localparam logic [4:0] LAST  = 5'd31;
    localparam int         LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        debug_mode_i, csr_req_i, csr_we_i;
    logic [4:0]  csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic        csr_gnt_o, csr_rvalid_o, csr_err_o;
    logic [31:0] csr_rdata_o;
    logic        sweep_start_i, sweep_busy_o, sweep_valid_o, sweep_ready_i, sweep_last_o;
    logic [4:0]  sweep_addr_o, pc_addr_o;
    logic [31:0] sweep_data_o, pc_data_o, pc_data_i;
    logic        pc_we_o;

    perf_counters_ctrl #(.FIRST_ADDR(FIRST), .LAST_ADDR(LAST), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(debug_mode_i),
        .csr_req_i(csr_req_i), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
        .csr_wdata_i(csr_wdata_i), .csr_gnt_o(csr_gnt_o), .csr_rvalid_o(csr_rvalid_o),
        .csr_rdata_o(csr_rdata_o), .csr_err_o(csr_err_o),
        .sweep_start_i(sweep_start_i), .sweep_busy_o(sweep_busy_o),
        .sweep_valid_o(sweep_valid_o), .sweep_ready_i(sweep_ready_i),
        .sweep_addr_o(sweep_addr_o), .sweep_data_o(sweep_data_o), .sweep_last_o(sweep_last_o),
        .pc_addr_o(pc_addr_o), .pc_we_o(pc_we_o), .pc_data_o(pc_data_o), .pc_data_i(pc_data_i)
    );

    always #5 clk = ~clk;

    // Counter file seen by the DUT, and the bench's own view of it.
    logic [31:0] cnt[32];
    logic [31:0] ref_cnt[32];
    assign pc_data_i = cnt[pc_addr_o];
    always @(posedge clk) if (pc_we_o) cnt[pc_addr_o] <= pc_data_o;

    typedef struct { logic [31:0] data; logic err; int cyc; } csr_exp_t;
    typedef struct { logic [4:0] addr; logic [31:0] data; logic last; } beat_t;
    csr_exp_t cq[$];
    beat_t    sq[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int losses = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            csr_exp_t e;
            logic     in_read, gexp, prot;

            // CSR responses
            if (csr_rvalid_o) begin
                if (cq.size() == 0) chk("csr_rvalid_spurious", 32'd1, 32'd0);
                else begin
                    e = cq.pop_front();
                    chk("csr_rdata", csr_rdata_o, e.data);
                    chk("csr_err", 32'(csr_err_o), 32'(e.err));
                    chk("csr_latency", 32'(cyc), 32'(e.cyc + 1));
                end
            end else if (cq.size() != 0 && cq[0].cyc < cyc) begin
                e = cq.pop_front();
                chk("csr_rvalid_missing", 32'd0, 32'd1);
            end

            chk("sweep_busy", 32'(sweep_busy_o), 32'(sq.size() != 0));

            // Arbitration from the starvation rule
            in_read = (sq.size() != 0) && !sweep_valid_o;
            gexp    = csr_req_i && !(in_read && losses == LIMIT);
            chk("csr_gnt", 32'(csr_gnt_o), 32'(gexp));
            losses  = (in_read && gexp) ? losses + 1 : 0;
`ifdef PERF_CTRL_DBG_WPROT_EN
            prot = debug_mode_i && csr_we_i;
`else
            prot = 1'b0;
`endif
            if (gexp) begin
                chk("pc_addr_csr", 32'(pc_addr_o), 32'(csr_addr_i));
                chk("pc_we_csr", 32'(pc_we_o), 32'(csr_we_i && !prot));
                if (csr_we_i && !prot) chk("pc_data_csr", pc_data_o, csr_wdata_i);
                e.data = csr_we_i ? 32'd0 : ref_cnt[csr_addr_i];
                e.err  = prot;
                e.cyc  = cyc;
                cq.push_back(e);
                if (csr_we_i && !prot) ref_cnt[csr_addr_i] = csr_wdata_i;
            end else if (in_read) begin
                chk("pc_addr_sweep", 32'(pc_addr_o), 32'(sq[0].addr));
                chk("pc_we_sweep", 32'(pc_we_o), 32'd0);
            end else begin
                chk("pc_we_idle", 32'(pc_we_o), 32'd0);
                chk("pc_addr_idle", 32'(pc_addr_o), 32'd0);
            end

            // Sweep beats
            if (sweep_start_i && sq.size() == 0) begin
                for (int a = int'(FIRST); a <= int'(LAST); a++) begin
                    beat_t b;
                    b.addr = 5'(a);
                    b.data = ref_cnt[a];
                    b.last = (5'(a) == LAST);
                    sq.push_back(b);
                end
            end else if (sweep_valid_o) begin
                if (sq.size() == 0) chk("sweep_valid_spurious", 32'd1, 32'd0);
                else begin
                    chk("sweep_addr", 32'(sweep_addr_o), 32'(sq[0].addr));
                    chk("sweep_data", sweep_data_o, sq[0].data);
                    chk("sweep_last", 32'(sweep_last_o), 32'(sq[0].last));
                    if (sweep_ready_i) void'(sq.pop_front());
                end
            end
        end
    end

    // Driver helpers: called at posedge+1, return at the next posedge+1
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic csr_op(input logic we, input logic [4:0] a, input logic [31:0] d);
        csr_req_i = 1'b1; csr_we_i = we; csr_addr_i = a; csr_wdata_i = d;
        step();
        csr_req_i = 1'b0; csr_we_i = 1'b0;
    endtask

    task automatic pulse_start();
        sweep_start_i = 1'b1;
        step();
        sweep_start_i = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string nm);
        int t;
        t = 0;
        while (sweep_busy_o && t < limit) begin
            step();
            t++;
        end
        chk(nm, 32'(sweep_busy_o), 32'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_csr_rvalid", 32'(csr_rvalid_o), 32'd0);
        chk("rst_csr_rdata", csr_rdata_o, 32'd0);
        chk("rst_csr_err", 32'(csr_err_o), 32'd0);
        chk("rst_sweep_busy", 32'(sweep_busy_o), 32'd0);
        chk("rst_sweep_valid", 32'(sweep_valid_o), 32'd0);
        chk("rst_sweep_addr", 32'(sweep_addr_o), 32'd0);
        chk("rst_sweep_data", sweep_data_o, 32'd0);
        chk("rst_sweep_last", 32'(sweep_last_o), 32'd0);
        chk("rst_pc_addr", 32'(pc_addr_o), 32'd0);
        chk("rst_pc_we", 32'(pc_we_o), 32'd0);
        chk("rst_pc_data", pc_data_o, 32'd0);
        chk("rst_csr_gnt", 32'(csr_gnt_o), 32'd0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        debug_mode_i = 1'b0; csr_req_i = 1'b0; csr_we_i = 1'b0;
        csr_addr_i = '0; csr_wdata_i = '0; sweep_start_i = 1'b0; sweep_ready_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            cnt[i]     = $urandom;
            ref_cnt[i] = cnt[i];
        end
        cnt[5] = 32'hA5; ref_cnt[5] = 32'hA5;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        step();

        // Directed CSR read and write
        csr_op(1'b0, 5'd5, 32'd0);
        csr_op(1'b1, 5'd7, 32'h1234);
        csr_op(1'b0, 5'd7, 32'd0);
        step();

        // Random CSR traffic while idle, including back-to-back grants
        for (int i = 0; i < 60; i++) begin
            csr_req_i    = ($urandom_range(3, 0) != 0);
            csr_we_i     = $urandom_range(1, 0) == 1;
            csr_addr_i   = 5'($urandom_range(31, 0));
            csr_wdata_i  = $urandom;
            debug_mode_i = ($urandom_range(3, 0) == 0);
            step();
        end
        csr_req_i = 1'b0; debug_mode_i = 1'b0;
        step();

        // Full sweep, no CSR traffic, ready held high: 29 beats, 2 cycles each
        sweep_ready_i = 1'b1;
        pulse_start();
        k = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!sweep_busy_o) break;
            k++;
        end
        chk("sweep_cycles", 32'(k), 32'd58);
        step();

        // Continuous CSR reads during a sweep: starvation forcing must complete it
        pulse_start();
        csr_req_i = 1'b1; csr_we_i = 1'b0;
        k = 0;
        while (sweep_busy_o && k < 1000) begin
            csr_addr_i = 5'($urandom_range(31, 0));
            step();
            k++;
        end
        chk("starve_sweep_done", 32'(sweep_busy_o), 32'd0);
        csr_req_i = 1'b0;
        step();

        // Stall at addr 9 for 10 cycles with an ignored start pulse
        pulse_start();
        k = 0;
        while (!(sweep_valid_o && sweep_addr_o == 5'd8) && k < 100) begin
            step();
            k++;
        end
        chk("reach_addr8", 32'(sweep_addr_o), 32'd8);
        step();
        sweep_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sweep_start_i = (i == 4);
            step();
        end
        sweep_start_i = 1'b0;
        chk("stall_addr9", 32'(sweep_addr_o), 32'd9);
        sweep_ready_i = 1'b1;
        wait_idle(200, "stall_sweep_done");
        step();

        // Random sweep: random ready, CSR reads anywhere, writes below the range
        pulse_start();
        k = 0;
        while (sweep_busy_o && k < 3000) begin
            sweep_ready_i = $urandom_range(1, 0) == 1;
            csr_req_i     = $urandom_range(1, 0) == 1;
            csr_we_i      = $urandom_range(3, 0) == 0;
            csr_addr_i    = csr_we_i ? 5'($urandom_range(2, 0)) : 5'($urandom_range(31, 0));
            csr_wdata_i   = $urandom;
            debug_mode_i  = $urandom_range(1, 0) == 1;
            step();
            k++;
        end
        chk("random_sweep_done", 32'(sweep_busy_o), 32'd0);
        csr_req_i = 1'b0; sweep_ready_i = 1'b1;
        step();

        // Debug-mode write then read back of the same counter
        debug_mode_i = 1'b1;
        csr_op(1'b1, 5'd4, 32'hDEAD_BEEF);
        debug_mode_i = 1'b0;
        csr_op(1'b0, 5'd4, 32'd0);
        step();

        // Reset in the middle of a sweep with a CSR response in flight
        pulse_start();
        for (int i = 0; i < 14; i++) step();
        csr_req_i = 1'b1; csr_we_i = 1'b0; csr_addr_i = 5'd6;
        @(posedge clk); #1;
        csr_req_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        sq.delete();
        cq.delete();
        losses = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("post_rst_valid", 32'(sweep_valid_o), 32'd0);
        csr_op(1'b0, 5'd6, 32'd0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
